// File: rtl/alu_operand_stage.sv
// alu_operand_stage
//   ID/EX operand stage. It selects ALU operand A (rs1 / pc / zero) and
//   operand B (rs2 / imm / constant 4) and registers them, together with the
//   store data (resolved rs2), behind a valid/ready handshake.
//
//   Optional feature macro: ALU_OPSEL_FWD_EN
//     defined   -> operand forwarding from NUM_FWD later pipeline stages.
//                  The lowest index has the highest priority. A used source
//                  whose winning match is still pending (load in flight)
//                  stalls decode.
//     undefined -> fwd_* ports are ignored, rs1/rs2 pass through raw, and
//                  stall is tied low.
module alu_operand_stage #(
    parameter int WIDTH   = 32,
    parameter int NUM_FWD = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [4:0]               rs1_addr,
    input  logic [4:0]               rs2_addr,
    input  logic [WIDTH-1:0]         rs1_data,
    input  logic [WIDTH-1:0]         rs2_data,
    input  logic [WIDTH-1:0]         imm,
    input  logic [WIDTH-1:0]         pc,
    input  logic [1:0]               src_a_sel,
    input  logic [1:0]               src_b_sel,
    input  logic [NUM_FWD-1:0]       fwd_valid,
    input  logic [NUM_FWD-1:0]       fwd_pending,
    input  logic [5*NUM_FWD-1:0]     fwd_rd,
    input  logic [WIDTH*NUM_FWD-1:0] fwd_data,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         op_a,
    output logic [WIDTH-1:0]         op_b,
    output logic [WIDTH-1:0]         store_data
);

    // Constant 4, zero-extended to the datapath width (WIDTH >= 8).
    localparam logic [WIDTH-1:0] CONST_FOUR = {{(WIDTH-3){1'b0}}, 3'b100};

    // Result of resolving one source register against the forwarding entries.
    typedef struct packed {
        logic             pend;
        logic [WIDTH-1:0] data;
    } resolved_t;

    logic [WIDTH-1:0] rs1_res_s;
    logic [WIDTH-1:0] rs2_res_s;
    logic             stall_s;
    logic             load_s;
    logic [WIDTH-1:0] op_a_s;
    logic [WIDTH-1:0] op_b_s;
    logic             out_valid_r;
    logic [WIDTH-1:0] op_a_r;
    logic [WIDTH-1:0] op_b_r;
    logic [WIDTH-1:0] store_data_r;

`ifdef ALU_OPSEL_FWD_EN
    // Walk the entries from lowest to highest priority, so the lowest
    // matching index is written last and wins. x0 never matches.
    function automatic resolved_t resolve(
        input logic [4:0]               addr,
        input logic [WIDTH-1:0]         raw,
        input logic [NUM_FWD-1:0]       valid,
        input logic [NUM_FWD-1:0]       pending,
        input logic [5*NUM_FWD-1:0]     rd,
        input logic [WIDTH*NUM_FWD-1:0] data
    );
        resolved_t res;
        res.pend = 1'b0;
        res.data = raw;
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (valid[i] && (rd[5*i +: 5] == addr) && (addr != 5'd0)) begin
                res.pend = pending[i];
                res.data = data[WIDTH*i +: WIDTH];
            end
        end
        return res;
    endfunction

    resolved_t rs1_fwd_s;
    resolved_t rs2_fwd_s;

    // Resolve both sources. rs1 stalls only when operand A selects it.
    // rs2 always feeds store_data, so a pending rs2 always stalls.
    always_comb begin
        rs1_fwd_s = resolve(rs1_addr, rs1_data, fwd_valid, fwd_pending, fwd_rd, fwd_data);
        rs2_fwd_s = resolve(rs2_addr, rs2_data, fwd_valid, fwd_pending, fwd_rd, fwd_data);
        rs1_res_s = rs1_fwd_s.data;
        rs2_res_s = rs2_fwd_s.data;
        stall_s   = ((src_a_sel == 2'd0) && rs1_fwd_s.pend) || rs2_fwd_s.pend;
    end
`else
    // Forwarding sideband is unused in this build.
    logic unused_fwd_s;
    assign unused_fwd_s = ^{fwd_valid, fwd_pending, fwd_rd, fwd_data, rs1_addr, rs2_addr};

    // No bypass network: the register file writes before it reads.
    always_comb begin
        rs1_res_s = rs1_data;
        rs2_res_s = rs2_data;
        stall_s   = 1'b0;
    end
`endif

    // Operand muxes. Immediates and pc are never forwarded. Reserved
    // selects yield zero.
    always_comb begin
        op_a_s = {WIDTH{1'b0}};
        op_b_s = {WIDTH{1'b0}};
        case (src_a_sel)
            2'd0:    op_a_s = rs1_res_s;
            2'd1:    op_a_s = pc;
            2'd2:    op_a_s = {WIDTH{1'b0}};
            default: op_a_s = {WIDTH{1'b0}};
        endcase
        case (src_b_sel)
            2'd0:    op_b_s = rs2_res_s;
            2'd1:    op_b_s = imm;
            2'd2:    op_b_s = CONST_FOUR;
            default: op_b_s = {WIDTH{1'b0}};
        endcase
    end

    // Handshake. in_ready does not depend on in_valid.
    always_comb begin
        in_ready = !stall_s && (!out_valid_r || out_ready) && !flush;
        load_s   = in_valid && in_ready;
    end

    // Valid flag. Flush beats load, and a consumed output with no new
    // load leaves a bubble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_r <= 1'b0;
        end else if (flush) begin
            out_valid_r <= 1'b0;
        end else if (load_s) begin
            out_valid_r <= 1'b1;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    // Operand registers. They capture only in the load cycle and stay
    // stable under backpressure.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_a_r       <= {WIDTH{1'b0}};
            op_b_r       <= {WIDTH{1'b0}};
            store_data_r <= {WIDTH{1'b0}};
        end else if (load_s) begin
            op_a_r       <= op_a_s;
            op_b_r       <= op_b_s;
            store_data_r <= rs2_res_s;
        end else begin
            op_a_r       <= op_a_r;
            op_b_r       <= op_b_r;
            store_data_r <= store_data_r;
        end
    end

    assign out_valid  = out_valid_r;
    assign op_a       = op_a_r;
    assign op_b       = op_b_r;
    assign store_data = store_data_r;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage with a scoreboard queue. Expected
// operands are pushed when the bench expects an accept and compared while
// out_valid is high. Expectations follow the build: forwarded values with
// ALU_OPSEL_FWD_EN, raw register data without it.
module tb_alu_operand_stage;

`ifdef ALU_OPSEL_FWD_EN
    localparam bit F = 1'b1;
`else
    localparam bit F = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] rs1_data, rs2_data, imm, pc;
    logic [1:0]  src_a_sel, src_b_sel;
    logic [1:0]  fwd_valid, fwd_pending;
    logic [9:0]  fwd_rd;
    logic [63:0] fwd_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] op_a, op_b, store_data;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] s;
    } exp_t;

    exp_t sb[$];
    bit   m_ov;
    int   checks = 0;
    int   errors = 0;

    alu_operand_stage #(.WIDTH(32), .NUM_FWD(2)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data),
        .rs2_data(rs2_data), .imm(imm), .pc(pc), .src_a_sel(src_a_sel),
        .src_b_sel(src_b_sel), .fwd_valid(fwd_valid), .fwd_pending(fwd_pending),
        .fwd_rd(fwd_rd), .fwd_data(fwd_data), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .op_a(op_a), .op_b(op_b), .store_data(store_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic clr();
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        rs1_addr = 5'd0; rs2_addr = 5'd0; rs1_data = 32'd0; rs2_data = 32'd0;
        imm = 32'd0; pc = 32'd0; src_a_sel = 2'd0; src_b_sel = 2'd0;
        fwd_valid = 2'b00; fwd_pending = 2'b00; fwd_rd = 10'd0; fwd_data = 64'd0;
    endtask

    // One cycle. The bench drives inputs at posedge+1 and checks at the
    // negedge. st is the expected stall; ea/eb/es are the operands expected
    // if this cycle loads.
    task automatic step(input bit st, input logic [31:0] ea, input logic [31:0] eb,
                        input logic [31:0] es);
        bit   rdy_e;
        exp_t e;
        @(negedge clk);
        rdy_e = !st && (!m_ov || out_ready) && !flush;
        chk("in_ready", {31'd0, in_ready}, {31'd0, rdy_e});
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_ov});
        if (m_ov && sb.size() > 0) begin
            e = sb[0];
            chk("op_a", op_a, e.a);
            chk("op_b", op_b, e.b);
            chk("store_data", store_data, e.s);
        end
        if (flush) begin
            sb.delete();
            m_ov = 1'b0;
        end else begin
            if (m_ov && out_ready && sb.size() > 0) sb.delete(0);
            if (in_valid && rdy_e) begin
                sb.push_back('{ea, eb, es});
                m_ov = 1'b1;
            end else if (out_ready) begin
                m_ov = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        clr();
        reset = 1'b1;
        m_ov  = 1'b0;
        #12;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_op_a", op_a, 32'd0);
        chk("rst_op_b", op_b, 32'd0);
        chk("rst_store", store_data, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;

        // rs1 with immediate
        clr(); in_valid = 1'b1; src_a_sel = 2'd0; src_b_sel = 2'd1;
        rs1_data = 32'h10; imm = 32'hFFFF_FFF0;
        step(1'b0, 32'h10, 32'hFFFF_FFF0, 32'h0);

        // two matching entries: index 0 wins
        rs1_addr = 5'd3; rs1_data = 32'h20; rs2_addr = 5'd5; rs2_data = 32'h1;
        fwd_valid = 2'b11; fwd_rd = {5'd5, 5'd5}; fwd_data = {32'hBB, 32'hAA};
        src_a_sel = 2'd0; src_b_sel = 2'd0;
        step(1'b0, 32'h20, F ? 32'hAA : 32'h1, F ? 32'hAA : 32'h1);

        // x0 is never forwarded
        clr(); in_valid = 1'b1; rs1_data = 32'h1234; rs2_data = 32'h77;
        fwd_valid = 2'b01; fwd_data = {32'h0, 32'hDEAD}; src_b_sel = 2'd2;
        step(1'b0, 32'h1234, 32'h4, 32'h77);

        // pending rs1 used by op_a stalls, then resolves
        clr(); in_valid = 1'b1; rs1_addr = 5'd7; rs1_data = 32'h99;
        src_b_sel = 2'd1; imm = 32'h3;
        fwd_valid = 2'b01; fwd_rd = {5'd0, 5'd7}; fwd_pending = 2'b01;
        fwd_data = {32'h0, 32'h55};
        step(F, 32'h99, 32'h3, 32'h0);
        fwd_pending = 2'b00;
        step(1'b0, F ? 32'h55 : 32'h99, 32'h3, 32'h0);

        // pending low-priority match hidden by a ready high-priority one
        fwd_valid = 2'b11; fwd_rd = {5'd7, 5'd7}; fwd_pending = 2'b10;
        fwd_data = {32'h77, 32'h66};
        step(1'b0, F ? 32'h66 : 32'h99, 32'h3, 32'h0);

        // op_a from pc: pending rs1 is unused, so no stall
        fwd_valid = 2'b01; fwd_rd = {5'd0, 5'd7}; fwd_pending = 2'b01;
        src_a_sel = 2'd1; pc = 32'h400;
        step(1'b0, 32'h400, 32'h3, 32'h0);

        // pending rs2 stalls through store_data even with op_b = imm
        rs2_addr = 5'd9; rs2_data = 32'h5; fwd_valid = 2'b10; fwd_rd = {5'd9, 5'd0};
        fwd_pending = 2'b10; fwd_data = {32'h888, 32'h0};
        step(F, 32'h400, 32'h3, 32'h5);
        fwd_pending = 2'b00;
        step(1'b0, 32'h400, 32'h3, F ? 32'h888 : 32'h5);

        // reserved selects give zero
        clr(); in_valid = 1'b1; src_a_sel = 2'd3; src_b_sel = 2'd3;
        rs1_data = 32'hFFFF; imm = 32'hFFFF; rs2_data = 32'h42;
        step(1'b0, 32'h0, 32'h0, 32'h42);
        clr();
        step(1'b0, 32'h0, 32'h0, 32'h0);

        // backpressure: held output stays stable while inputs change
        clr(); in_valid = 1'b1; src_a_sel = 2'd1; src_b_sel = 2'd1;
        pc = 32'h111; imm = 32'h222; rs2_data = 32'h333;
        step(1'b0, 32'h111, 32'h222, 32'h333);
        out_ready = 1'b0; pc = 32'hAAA; imm = 32'hBBB; rs2_data = 32'hCCC;
        for (int i = 0; i < 3; i++) step(1'b0, 32'hAAA, 32'hBBB, 32'hCCC);
        out_ready = 1'b1;
        step(1'b0, 32'hAAA, 32'hBBB, 32'hCCC);
        in_valid = 1'b0;
        step(1'b0, 32'h0, 32'h0, 32'h0);

        // flush drops a held output and blocks the incoming instruction
        in_valid = 1'b1; pc = 32'h1;
        step(1'b0, 32'h1, 32'hBBB, 32'hCCC);
        in_valid = 1'b0; out_ready = 1'b0;
        step(1'b0, 32'h0, 32'h0, 32'h0);
        flush = 1'b1; in_valid = 1'b1; pc = 32'h2;
        step(1'b0, 32'h2, 32'hBBB, 32'hCCC);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        step(1'b0, 32'h0, 32'h0, 32'h0);
        // flush and load with an empty stage
        flush = 1'b1; in_valid = 1'b1; pc = 32'h3;
        step(1'b0, 32'h3, 32'hBBB, 32'hCCC);
        flush = 1'b0; in_valid = 1'b0;
        step(1'b0, 32'h0, 32'h0, 32'h0);

        // back-to-back throughput
        clr(); src_a_sel = 2'd1; src_b_sel = 2'd2;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; pc = 32'h1000 + i;
            step(1'b0, 32'h1000 + i, 32'h4, 32'h0);
        end
        in_valid = 1'b0;
        step(1'b0, 32'h0, 32'h0, 32'h0);

        // reset mid-handshake clears out_valid immediately
        in_valid = 1'b1; pc = 32'hABC;
        step(1'b0, 32'hABC, 32'h4, 32'h0);
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_op_a", op_a, 32'd0);
        sb.delete();
        m_ov = 1'b0;
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        step(1'b0, 32'h0, 32'h0, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
